// File: rtl/tone_gen_if.sv
// Period handshake bundle between a period source and the tone generator.
// Latency: n/a (wires only).
// Backpressure: period_ready low means the source holds its offer; offers made while it is low are ignored.
interface tone_gen_if #(
  parameter int DATA_WIDTH = 12
) ();
  logic [DATA_WIDTH-1:0] period_in;
  logic                  period_valid;
  logic                  period_ready;

  // Period source side.
  modport master (
    output period_in,
    output period_valid,
    input  period_ready
  );

  // Tone generator side.
  modport slave (
    input  period_in,
    input  period_valid,
    output period_ready
  );
endinterface

// File: rtl/tone_gen.sv
// Square-wave tone generator: P-sample cycles of +amp (P-(P>>1) samples) then -amp (P>>1 samples).
// Latency: enable sampled high on an edge gives the first +amp sample right after that edge; enable low gives 0 after the next edge.
// Backpressure: one pending period slot; period_ready drops while it is full and frees at the next cycle boundary.
// Optional macro TONE_GEN_CYCLE_CNT_EN adds a 16-bit wrapping cycle_cnt output.
module tone_gen #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                         adc_clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [DATA_WIDTH-2:0]        amp,
  tone_gen_if.slave                    per_if,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         cycle_start,
`ifdef TONE_GEN_CYCLE_CNT_EN
  output logic [15:0]                  cycle_cnt,
`endif
  output logic                         period_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  // Pending slot holds the next period until the following cycle boundary.
  logic                   pend_vld;
  logic [DATA_WIDTH-1:0]  pend_per;
  // Active period governs the cycle in progress and never changes mid-cycle.
  logic                   act_vld;
  logic [DATA_WIDTH-1:0]  act_per;
  // Amplitude captured at the start of each cycle.
  logic [DATA_WIDTH-2:0]  amp_q;

  // Sample index within the current cycle, 0 .. P-1.
  logic [DATA_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0]  cnt_nxt;
  logic [DATA_WIDTH-1:0]  cnt_inc;
  logic [DATA_WIDTH-1:0]  hi_len;
  logic                   last_sample;
  logic                   have_period;

  logic signed [DATA_WIDTH-1:0] dout_nxt;
  logic signed [DATA_WIDTH-1:0] pos_now;
  logic signed [DATA_WIDTH-1:0] pos_hold;
  logic signed [DATA_WIDTH-1:0] neg_hold;
  logic                   start_nxt;
  logic                   begin_cycle;
  logic                   load_act;

  logic                   accept;
  logic                   per_ok;

  assign per_if.period_ready = ~pend_vld;
  assign accept              = per_if.period_valid & ~pend_vld;
  assign per_ok              = (per_if.period_in >= DATA_WIDTH'(2));

  assign have_period = pend_vld | act_vld;
  assign hi_len      = act_per - (act_per >> 1);
  assign cnt_inc     = cnt + DATA_WIDTH'(1);
  assign last_sample = (cnt == act_per - DATA_WIDTH'(1));

  assign pos_now  = $signed({1'b0, amp});
  assign pos_hold = $signed({1'b0, amp_q});
  assign neg_hold = $signed(DATA_WIDTH'(0) - {1'b0, amp_q});

  assign load_act = begin_cycle & pend_vld;

  // Next-state and next-sample decode; enable low overrides everything and parks in IDLE.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dout_nxt    = data_out;
    start_nxt   = 1'b0;
    begin_cycle = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        dout_nxt    = '0;
        begin_cycle = have_period;
      end
      HIGH, LOW: begin
        if (last_sample) begin
          begin_cycle = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc < hi_len) begin
            state_nxt = HIGH;
            dout_nxt  = pos_hold;
          end else begin
            state_nxt = LOW;
            dout_nxt  = neg_hold;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        dout_nxt  = '0;
      end
    endcase

    // A new cycle always opens on a HIGH sample with the live amp input.
    if (begin_cycle) begin
      state_nxt = HIGH;
      cnt_nxt   = '0;
      dout_nxt  = pos_now;
      start_nxt = 1'b1;
    end

    if (!enable) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      dout_nxt    = '0;
      start_nxt   = 1'b0;
      begin_cycle = 1'b0;
    end
  end

  // State, phase counter and registered outputs.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      data_out    <= '0;
      cycle_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      data_out    <= dout_nxt;
      cycle_start <= start_nxt;
    end
  end

  // Pending slot: filled by a valid offer, emptied when a cycle boundary consumes it; bad periods only flag an error.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      pend_vld   <= 1'b0;
      pend_per   <= '0;
      period_err <= 1'b0;
    end else begin
      if (load_act) begin
        pend_vld <= 1'b0;
      end else if (accept && per_ok) begin
        pend_vld <= 1'b1;
        pend_per <= per_if.period_in;
      end
      if (accept && !per_ok) begin
        period_err <= 1'b1;
      end
    end
  end

  // Active period and amplitude update only at a cycle boundary.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      act_vld <= 1'b0;
      act_per <= '0;
      amp_q   <= '0;
    end else if (begin_cycle) begin
      amp_q <= amp;
      if (pend_vld) begin
        act_vld <= 1'b1;
        act_per <= pend_per;
      end
    end
  end

`ifdef TONE_GEN_CYCLE_CNT_EN
  // Cycle counter advances on the same edge that raises cycle_start, wrapping naturally.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (start_nxt) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tone_gen.sv
// Randomized scoreboard bench for tone_gen against a waveform-list reference model.
// Latency: model predicts the outputs visible after each rising edge; monitor compares on the falling edge.
// Backpressure: offers are sometimes held while period_ready is low; the model ignores them as the DUT must.
module tb_tone_gen;
  localparam int W = 12;

  logic adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  logic                rst;
  logic                enable;
  logic [W-2:0]        amp;
  logic signed [W-1:0] data_out;
  logic                cycle_start;
  logic                period_err;
`ifdef TONE_GEN_CYCLE_CNT_EN
  logic [15:0]         cycle_cnt;
`endif

  tone_gen_if #(.DATA_WIDTH(W)) per_if ();

  tone_gen #(.DATA_WIDTH(W)) dut (
    .adc_clk     (adc_clk),
    .rst         (rst),
    .enable      (enable),
    .amp         (amp),
    .per_if      (per_if),
    .data_out    (data_out),
    .cycle_start (cycle_start),
`ifdef TONE_GEN_CYCLE_CNT_EN
    .cycle_cnt   (cycle_cnt),
`endif
    .period_err  (period_err)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         cs;
    logic         rdy;
    logic         err;
    logic [15:0]  ccnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: a list of samples still to be played in the current cycle.
  int wave[$];
  bit m_pend_has = 1'b0;
  int m_pend_val = 0;
  bit m_act_has  = 1'b0;
  int m_act_val  = 0;
  bit m_err      = 1'b0;
  int m_ccnt     = 0;

  // Predict the outputs that follow each rising edge from the inputs present at it.
  always @(posedge adc_clk) begin : model_b
    exp_t e;
    bit   acc;
    int   p;
    int   out_v;
    bit   cs_v;
    out_v = 0;
    cs_v  = 1'b0;
    if (rst) begin
      wave.delete();
      m_pend_has = 1'b0;
      m_act_has  = 1'b0;
      m_err      = 1'b0;
      m_ccnt     = 0;
    end else begin
      acc = per_if.period_valid && !m_pend_has;
      if (!enable) begin
        wave.delete();
      end else if (wave.size() == 0 && (m_pend_has || m_act_has)) begin
        if (m_pend_has) begin
          m_act_val  = m_pend_val;
          m_act_has  = 1'b1;
          m_pend_has = 1'b0;
        end
        p = m_act_val;
        for (int i = 0; i < p; i++)
          wave.push_back((i < p - p / 2) ? int'(amp) : -int'(amp));
        cs_v   = 1'b1;
        m_ccnt = (m_ccnt + 1) % 65536;
      end
      if (enable && wave.size() != 0) out_v = wave.pop_front();
      if (acc) begin
        if (int'(per_if.period_in) < 2) begin
          m_err = 1'b1;
        end else begin
          m_pend_has = 1'b1;
          m_pend_val = int'(per_if.period_in);
        end
      end
    end
    e.data = W'(out_v);
    e.cs   = cs_v;
    e.rdy  = !m_pend_has;
    e.err  = m_err;
    e.ccnt = 16'(m_ccnt);
    sb_q.push_back(e);
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Compare DUT outputs against the oldest prediction, away from the active edge.
  always @(negedge adc_clk) begin : monitor_b
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("data_out",     16'($unsigned(data_out)),   16'(e.data));
      chk("cycle_start",  16'(cycle_start),           16'(e.cs));
      chk("period_ready", 16'(per_if.period_ready),   16'(e.rdy));
      chk("period_err",   16'(period_err),            16'(e.err));
`ifdef TONE_GEN_CYCLE_CNT_EN
      chk("cycle_cnt",    cycle_cnt,                  e.ccnt);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge adc_clk);
      #1;
    end
  endtask

  task automatic offer(input int p);
    per_if.period_in    = W'(p);
    per_if.period_valid = 1'b1;
    tick(1);
    per_if.period_valid = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    enable              = 1'b0;
    amp                 = '0;
    per_if.period_in    = '0;
    per_if.period_valid = 1'b0;
    tick(3);
    rst = 1'b0;

    // P=10, amp=100, then offer P=20 at the third HIGH sample and keep offering while the slot is full.
    amp = 11'd100;
    offer(10);
    enable = 1'b1;
    tick(32);
    per_if.period_in    = W'(20);
    per_if.period_valid = 1'b1;
    tick(1);
    per_if.period_in    = W'(3);
    tick(1);
    per_if.period_valid = 1'b0;
    tick(60);

    // P=7 with an amplitude change that must only land at a boundary.
    offer(7);
    tick(9);
    amp = 11'd333;
    tick(30);

    // Invalid periods set the sticky error and leave the waveform alone.
    offer(1);
    tick(20);
    offer(0);
    tick(20);

    // Drop enable mid-cycle and restart.
    tick(3);
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(20);

    // Smallest legal periods.
    offer(2);
    tick(12);
    offer(3);
    tick(12);

    // Largest period must not wrap.
    amp = 11'd2047;
    offer((1 << W) - 1);
    tick(4200);
    offer(5);
    tick(30);

    // Reset mid-cycle, then start fresh.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);
    offer(6);
    tick(20);

    // Random traffic: amp jitter, random offers (including invalid), enable drops and rare resets.
    repeat (3000) begin
      amp = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 19) == 0) begin
        per_if.period_in    = W'($urandom_range(0, 30));
        per_if.period_valid = 1'b1;
      end else begin
        per_if.period_valid = 1'b0;
      end
      enable = ($urandom_range(0, 99) != 0);
      rst    = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst                 = 1'b0;
    enable              = 1'b0;
    per_if.period_valid = 1'b0;
    tick(2);
    @(negedge adc_clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tone_gen.md
TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, width of period, amplitude and sample words.
REQ-002 SHALL have port adc_clk  input  1  sample clock; sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  run request; 0 forces IDLE at next edge.
REQ-005 SHALL have port amp  input  DATA_WIDTH-1  unsigned magnitude, sampled at each HIGH entry.
REQ-006 SHALL have port period_in  input  DATA_WIDTH  requested period in samples.
REQ-007 SHALL have port period_valid  input  1  period_in offered.
REQ-008 SHALL have port period_ready  output  1  1 when pending slot empty.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  signed square-wave sample.
REQ-010 SHALL have port cycle_start  output  1  one-cycle pulse with first HIGH sample of each period.
REQ-011 SHALL have port period_err  output  1  sticky; set when an accepted period_in < 2.

Function
REQ-012 SHALL accept a period on any edge where period_valid && period_ready; accepted value goes to pending register, period_ready drops next cycle.
REQ-013 SHALL keep period_in stable-insensitive after acceptance; a second offer while period_ready=0 SHALL be ignored (no overwrite).
REQ-014 SHALL have FSM states IDLE, HIGH, LOW.
REQ-015 SHALL in IDLE drive data_out=0, and move to HIGH when enable=1 and a valid active period exists (pending or previously loaded).
REQ-016 SHALL load pending period into active register only at HIGH entry (period boundary), freeing the slot (period_ready=1 the following cycle); an active period never changes mid-cycle.
REQ-017 SHALL hold HIGH for P - (P>>1) samples, output +amp; then LOW for P>>1 samples, output -amp (two's complement); total exactly P samples per cycle (P=active period).
REQ-018 SHALL go LOW->HIGH directly after last LOW sample, with no gap sample; cycle_start asserted on that HIGH sample.
REQ-019 SHALL register data_out; first HIGH sample appears one cycle after the edge where the FSM leaves IDLE.
REQ-020 SHALL treat accepted period_in of 0 or 1 as invalid: set period_err, discard value, slot freed; running cycle continues with old period, or stays IDLE if none.
REQ-021 SHALL on enable=0 mid-cycle return to IDLE at next edge, output 0; on re-enable restart at HIGH with phase counter cleared.
REQ-022 SHALL size the phase counter DATA_WIDTH bits; P = 2^DATA_WIDTH-1 SHALL not wrap.
REQ-023 SHALL on simultaneous period acceptance and HIGH entry use the old pending (or active) value for this cycle; newly accepted value applies at the next boundary.

Reset
REQ-024 SHALL on rst=1 set: state IDLE, data_out=0, cycle_start=0, period_ready=1, period_err=0, active and pending periods invalid, counters 0.
REQ-025 SHALL let rst override enable and handshake on the same edge; mid-cycle reset discards the cycle.

Configuration
REQ-026 SHALL, with macro TONE_GEN_CYCLE_CNT_EN defined, add output cycle_cnt (16 bits), incremented on each cycle_start, wrapping 0xFFFF->0, cleared by rst.
REQ-027 SHALL, without TONE_GEN_CYCLE_CNT_EN, omit cycle_cnt port and logic; all other behaviour identical.

Verification
REQ-028 SHALL test: rst, load P=10, amp=100, enable=1 -> repeating 5x(+100), 5x(-100); cycle_start every 10 cycles.
REQ-029 SHALL test: P=7 -> 4x(+amp) then 3x(-amp), period exactly 7 samples.
REQ-030 SHALL test: P=10 running, offer P=20 mid-HIGH -> current cycle stays 10, next cycle 10x(+amp)/10x(-amp); period_ready=0 until that boundary.
REQ-031 SHALL test: offer P=1 -> period_err=1 sticky, waveform unchanged; only rst clears it.
REQ-032 SHALL test: enable=0 at sample 3 of HIGH -> data_out=0 next cycle; re-enable -> full HIGH half restarts, cycle_start pulses.
REQ-033 SHALL test: with TONE_GEN_CYCLE_CNT_EN, 3 cycles -> cycle_cnt=3; rst mid-cycle -> all outputs at reset values next cycle.
